// File: rtl/mpsoc_glip_packetizer_pkg.sv
// Shared types for the host-side GLIP framing stage: FSM encodings and word width.
package mpsoc_glip_packetizer_pkg;

  localparam int unsigned GLIP_WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    TxCollect,
    TxDrop,
    TxLen,
    TxBody
  } tx_state_t;

  typedef enum logic [1:0] {
    RxLen,
    RxBody,
    RxDrop
  } rx_state_t;

endpackage

// File: rtl/mpsoc_glip_tx_buffer.sv
// Single-write/single-read packet store for the TX path: registered write, combinational read.
module mpsoc_glip_tx_buffer
  import mpsoc_glip_packetizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = GLIP_WORD_WIDTH,
  parameter int unsigned DEPTH      = 12,
  parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mpsoc_glip_packetizer.sv
// Host-side GLIP framing: length-prefixes outgoing packets, strips and re-delimits incoming ones.
module mpsoc_glip_packetizer
  import mpsoc_glip_packetizer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = GLIP_WORD_WIDTH,
  parameter int unsigned MAX_PKT_LEN = 12,
  parameter int unsigned LEN_WIDTH   = $clog2(MAX_PKT_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] host_in_data,
  input  logic                  host_in_last,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  output logic [DATA_WIDTH-1:0] host_out_data,
  output logic                  host_out_last,
  output logic                  host_out_valid,
  input  logic                  host_out_ready,
  output logic [DATA_WIDTH-1:0] glip_in_data,
  output logic                  glip_in_valid,
  input  logic                  glip_in_ready,
  input  logic [DATA_WIDTH-1:0] glip_out_data,
  input  logic                  glip_out_valid,
  output logic                  glip_out_ready,
  output logic                  tx_drop,
  output logic                  rx_drop
);

  localparam int unsigned BufAw = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam logic [LEN_WIDTH-1:0]  MaxLen  = LEN_WIDTH'(MAX_PKT_LEN);
  localparam logic [LEN_WIDTH-1:0]  CntOne  = LEN_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MaxLenW = DATA_WIDTH'(MAX_PKT_LEN);
  localparam logic [DATA_WIDTH-1:0] RemOne  = DATA_WIDTH'(1);

  tx_state_t             tx_state_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic [LEN_WIDTH-1:0]  rd_q;
  logic                  tx_drop_q;
  rx_state_t             rx_state_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic                  rx_drop_q;

  logic                  tx_full;
  logic                  buf_wr_en;
  logic [DATA_WIDTH-1:0] buf_rd_data;

  assign tx_full   = (cnt_q == MaxLen);
  assign buf_wr_en = host_in_valid && (tx_state_q == TxCollect) && !tx_full;

  mpsoc_glip_tx_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_PKT_LEN),
    .ADDR_WIDTH (BufAw)
  ) u_tx_buffer (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (cnt_q[BufAw-1:0]),
    .wr_data (host_in_data),
    .rd_addr (rd_q[BufAw-1:0]),
    .rd_data (buf_rd_data)
  );

  // TX: store a whole packet first so its length is known before the first GLIP word goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxCollect;
      cnt_q      <= '0;
      rd_q       <= '0;
      tx_drop_q  <= 1'b0;
    end else begin
      tx_drop_q <= 1'b0;
      unique case (tx_state_q)
        TxCollect: begin
          if (host_in_valid) begin
            if (tx_full) begin
              if (host_in_last) begin
                tx_drop_q <= 1'b1;
                cnt_q     <= '0;
              end else begin
                tx_state_q <= TxDrop;
              end
            end else begin
              cnt_q <= cnt_q + CntOne;
              if (host_in_last) begin
                tx_state_q <= TxLen;
              end
            end
          end
        end
        TxDrop: begin
          if (host_in_valid && host_in_last) begin
            tx_drop_q  <= 1'b1;
            cnt_q      <= '0;
            tx_state_q <= TxCollect;
          end
        end
        TxLen: begin
          if (glip_in_ready) begin
            rd_q       <= '0;
            tx_state_q <= TxBody;
          end
        end
        TxBody: begin
          if (glip_in_ready) begin
            if (rd_q == cnt_q - CntOne) begin
              cnt_q      <= '0;
              tx_state_q <= TxCollect;
            end else begin
              rd_q <= rd_q + CntOne;
            end
          end
        end
        default: tx_state_q <= TxCollect;
      endcase
    end
  end

  // RX: rem spans the full word width so oversize packets are drained exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RxLen;
      rem_q      <= '0;
      rx_drop_q  <= 1'b0;
    end else begin
      rx_drop_q <= 1'b0;
      unique case (rx_state_q)
        RxLen: begin
          if (glip_out_valid && (glip_out_data != '0)) begin
            rem_q <= glip_out_data;
            if (glip_out_data > MaxLenW) begin
              rx_drop_q  <= 1'b1;
              rx_state_q <= RxDrop;
            end else begin
              rx_state_q <= RxBody;
            end
          end
        end
        RxBody: begin
          if (glip_out_valid && host_out_ready) begin
            rem_q <= rem_q - RemOne;
            if (rem_q == RemOne) begin
              rx_state_q <= RxLen;
            end
          end
        end
        RxDrop: begin
          if (glip_out_valid) begin
            rem_q <= rem_q - RemOne;
            if (rem_q == RemOne) begin
              rx_state_q <= RxLen;
            end
          end
        end
        default: rx_state_q <= RxLen;
      endcase
    end
  end

  // Outputs are forced low while rst is high, including the first reset cycle.
  always_comb begin
    host_in_ready = 1'b0;
    glip_in_valid = 1'b0;
    glip_in_data  = '0;
    tx_drop       = 1'b0;
    if (!rst) begin
      tx_drop = tx_drop_q;
      unique case (tx_state_q)
        TxCollect, TxDrop: host_in_ready = 1'b1;
        TxLen: begin
          glip_in_valid = 1'b1;
          glip_in_data  = DATA_WIDTH'(cnt_q);
        end
        TxBody: begin
          glip_in_valid = 1'b1;
          glip_in_data  = buf_rd_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    glip_out_ready = 1'b0;
    host_out_valid = 1'b0;
    host_out_data  = '0;
    host_out_last  = 1'b0;
    rx_drop        = 1'b0;
    if (!rst) begin
      rx_drop = rx_drop_q;
      unique case (rx_state_q)
        RxLen, RxDrop: glip_out_ready = 1'b1;
        RxBody: begin
          host_out_valid = glip_out_valid;
          glip_out_ready = host_out_ready;
          host_out_data  = glip_out_data;
          host_out_last  = (rem_q == RemOne);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_glip_packetizer.sv
// Directed self-checking bench for mpsoc_glip_packetizer (TX framing, RX de-framing, drops, reset).
module tb_mpsoc_glip_packetizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] host_in_data = '0;
  logic        host_in_last = 1'b0;
  logic        host_in_valid = 1'b0;
  logic        host_in_ready;
  logic [15:0] host_out_data;
  logic        host_out_last;
  logic        host_out_valid;
  logic        host_out_ready = 1'b0;
  logic [15:0] glip_in_data;
  logic        glip_in_valid;
  logic        glip_in_ready = 1'b0;
  logic [15:0] glip_out_data = '0;
  logic        glip_out_valid = 1'b0;
  logic        glip_out_ready;
  logic        tx_drop;
  logic        rx_drop;

  int errors = 0;
  int checks = 0;

  logic [15:0] glip_q[$];
  logic [16:0] host_q[$];
  logic [15:0] exp_q[$];
  int          tx_drop_seen = 0;
  int          rx_drop_seen = 0;
  int          base_tx;
  int          base_rx;

  logic        gi_stall = 1'b0;
  logic        ho_stall = 1'b0;
  logic [15:0] gi_prev = '0;
  logic [16:0] ho_prev = '0;

  mpsoc_glip_packetizer #(
    .DATA_WIDTH  (16),
    .MAX_PKT_LEN (12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host_in_data   (host_in_data),
    .host_in_last   (host_in_last),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_last  (host_out_last),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .glip_in_data   (glip_in_data),
    .glip_in_valid  (glip_in_valid),
    .glip_in_ready  (glip_in_ready),
    .glip_out_data  (glip_out_data),
    .glip_out_valid (glip_out_valid),
    .glip_out_ready (glip_out_ready),
    .tx_drop        (tx_drop),
    .rx_drop        (rx_drop)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transfers are recorded at the falling edge, where inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      gi_stall <= 1'b0;
      ho_stall <= 1'b0;
    end else begin
      if (gi_stall) begin
        check_eq("glip_in_hold_valid", {31'd0, glip_in_valid}, 32'd1);
        check_eq("glip_in_hold_data", {16'd0, glip_in_data}, {16'd0, gi_prev});
      end
      if (ho_stall) begin
        check_eq("host_out_hold_valid", {31'd0, host_out_valid}, 32'd1);
        check_eq("host_out_hold_data", {15'd0, host_out_last, host_out_data}, {15'd0, ho_prev});
      end
      if (glip_in_valid && glip_in_ready) glip_q.push_back(glip_in_data);
      if (host_out_valid && host_out_ready) host_q.push_back({host_out_last, host_out_data});
      if (tx_drop) tx_drop_seen <= tx_drop_seen + 1;
      if (rx_drop) rx_drop_seen <= rx_drop_seen + 1;
      gi_stall <= glip_in_valid && !glip_in_ready;
      gi_prev  <= glip_in_data;
      ho_stall <= host_out_valid && !host_out_ready;
      ho_prev  <= {host_out_last, host_out_data};
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_send(input logic [15:0] w, input logic last);
    bit ok = 1'b0;
    host_in_data  = w;
    host_in_last  = last;
    host_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (host_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("host_in_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    host_in_valid = 1'b0;
    host_in_last  = 1'b0;
  endtask

  task automatic glip_send(input logic [15:0] w);
    bit ok = 1'b0;
    glip_out_data  = w;
    glip_out_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (glip_out_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("glip_out_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    glip_out_valid = 1'b0;
  endtask

  task automatic check_glip(input string tag);
    check_eq({tag, "_len"}, glip_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < glip_q.size()) check_eq(tag, {16'd0, glip_q[i]}, {16'd0, exp_q[i]});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_host_in_ready"}, {31'd0, host_in_ready}, 32'd0);
    check_eq({tag, "_glip_out_ready"}, {31'd0, glip_out_ready}, 32'd0);
    check_eq({tag, "_glip_in_valid"}, {31'd0, glip_in_valid}, 32'd0);
    check_eq({tag, "_host_out_valid"}, {31'd0, host_out_valid}, 32'd0);
    check_eq({tag, "_glip_in_data"}, {16'd0, glip_in_data}, 32'd0);
    check_eq({tag, "_host_out_data"}, {16'd0, host_out_data}, 32'd0);
    check_eq({tag, "_host_out_last"}, {31'd0, host_out_last}, 32'd0);
    check_eq({tag, "_drops"}, {30'd0, tx_drop, rx_drop}, 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] tx_exp [4];
    tx_exp[0] = 16'h0003;
    tx_exp[1] = 16'h1111;
    tx_exp[2] = 16'h2222;
    tx_exp[3] = 16'h3333;

    // Reset with active inputs: pass-through must stay gated.
    glip_out_valid = 1'b1;
    glip_out_data  = 16'h00FF;
    host_out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    glip_out_valid = 1'b0;
    glip_out_data  = '0;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset_host_in_ready", {31'd0, host_in_ready}, 32'd1);
    check_eq("post_reset_glip_out_ready", {31'd0, glip_out_ready}, 32'd1);
    check_eq("post_reset_glip_in_valid", {31'd0, glip_in_valid}, 32'd0);
    check_eq("post_reset_host_out_valid", {31'd0, host_out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Single TX packet, checked cycle by cycle.
    glip_in_ready = 1'b1;
    host_send(16'h1111, 1'b0);
    host_send(16'h2222, 1'b0);
    host_send(16'h3333, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("tx_single_valid", {31'd0, glip_in_valid}, 32'd1);
      check_eq("tx_single_data", {16'd0, glip_in_data}, {16'd0, tx_exp[k]});
      check_eq("tx_single_host_busy", {31'd0, host_in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_eq("tx_single_done_ready", {31'd0, host_in_ready}, 32'd1);
    check_eq("tx_single_done_valid", {31'd0, glip_in_valid}, 32'd0);
    @(posedge clk);
    #1;

    // TX overflow: 14 words are dropped, then a 1-word packet goes through.
    glip_q.delete();
    base_tx = tx_drop_seen;
    for (int i = 0; i < 14; i++) host_send(16'h0100 + 16'(i), (i == 13));
    @(negedge clk);
    check_eq("tx_ovf_drop_pulse", {31'd0, tx_drop}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("tx_ovf_drop_low", {31'd0, tx_drop}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("tx_ovf_no_glip", glip_q.size(), 32'd0);
    check_eq("tx_ovf_drop_count", tx_drop_seen - base_tx, 32'd1);
    host_send(16'hABCD, 1'b1);
    idle(4);
    exp_q = {16'h0001, 16'hABCD};
    check_glip("tx_ovf_next");

    // Exactly MAX_PKT_LEN words must still transmit.
    glip_q.delete();
    exp_q.delete();
    exp_q.push_back(16'd12);
    for (int i = 0; i < 12; i++) begin
      host_send(16'h0C00 + 16'(i), (i == 11));
      exp_q.push_back(16'h0C00 + 16'(i));
    end
    idle(16);
    check_glip("tx_max");
    check_eq("tx_max_no_drop", tx_drop_seen - base_tx, 32'd1);

    // RX normal with idle filler.
    host_q.delete();
    base_rx = rx_drop_seen;
    glip_send(16'h0000);
    glip_send(16'h0002);
    glip_send(16'hBEEF);
    glip_send(16'hCAFE);
    idle(2);
    check_eq("rx_norm_len", host_q.size(), 32'd2);
    if (host_q.size() == 2) begin
      check_eq("rx_norm_w0", {15'd0, host_q[0]}, {15'd0, 1'b0, 16'hBEEF});
      check_eq("rx_norm_w1", {15'd0, host_q[1]}, {15'd0, 1'b1, 16'hCAFE});
    end

    // RX oversize: 20-word packet drained silently.
    host_q.delete();
    glip_send(16'h0014);
    for (int i = 0; i < 20; i++) glip_send(16'h4000 + 16'(i));
    glip_send(16'h0001);
    glip_send(16'h5A5A);
    idle(2);
    check_eq("rx_ovs_drop_count", rx_drop_seen - base_rx, 32'd1);
    check_eq("rx_ovs_len", host_q.size(), 32'd1);
    if (host_q.size() == 1) check_eq("rx_ovs_word", {15'd0, host_q[0]}, {15'd0, 1'b1, 16'h5A5A});

    // RX boundary: length equal to MAX_PKT_LEN is delivered.
    host_q.delete();
    glip_send(16'h000C);
    for (int i = 0; i < 12; i++) glip_send(16'h6000 + 16'(i));
    idle(2);
    check_eq("rx_max_len", host_q.size(), 32'd12);
    if (host_q.size() == 12) begin
      check_eq("rx_max_first", {15'd0, host_q[0]}, {15'd0, 1'b0, 16'h6000});
      check_eq("rx_max_penult", {15'd0, host_q[10]}, {15'd0, 1'b0, 16'h600A});
      check_eq("rx_max_last", {15'd0, host_q[11]}, {15'd0, 1'b1, 16'h600B});
    end
    check_eq("rx_max_no_drop", rx_drop_seen - base_rx, 32'd1);

    // Random backpressure on both paths at once.
    glip_q.delete();
    host_q.delete();
    fork
      begin
        for (int i = 0; i < 5; i++) host_send(16'h7000 + 16'(i), (i == 4));
      end
      begin
        glip_send(16'h0003);
        glip_send(16'hD001);
        glip_send(16'hD002);
        glip_send(16'hD003);
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          glip_in_ready  = 1'($urandom_range(0, 1));
          host_out_ready = 1'($urandom_range(0, 1));
        end
        glip_in_ready  = 1'b1;
        host_out_ready = 1'b1;
      end
    join
    idle(10);
    exp_q = {16'h0005, 16'h7000, 16'h7001, 16'h7002, 16'h7003, 16'h7004};
    check_glip("bp_tx");
    check_eq("bp_rx_len", host_q.size(), 32'd3);
    if (host_q.size() == 3) begin
      check_eq("bp_rx_w0", {15'd0, host_q[0]}, {15'd0, 1'b0, 16'hD001});
      check_eq("bp_rx_w1", {15'd0, host_q[1]}, {15'd0, 1'b0, 16'hD002});
      check_eq("bp_rx_w2", {15'd0, host_q[2]}, {15'd0, 1'b1, 16'hD003});
    end

    // Reset while stalled in the TX body.
    base_tx = tx_drop_seen;
    base_rx = rx_drop_seen;
    glip_in_ready = 1'b0;
    host_send(16'h9000, 1'b0);
    host_send(16'h9001, 1'b0);
    host_send(16'h9002, 1'b1);
    glip_in_ready = 1'b1;
    idle(1);
    glip_in_ready = 1'b0;
    idle(2);
    @(negedge clk);
    check_eq("mid_body_valid", {31'd0, glip_in_valid}, 32'd1);
    check_eq("mid_body_data", {16'd0, glip_in_data}, 32'h9000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    glip_out_valid = 1'b1;
    glip_out_data  = 16'h0001;
    idle(1);
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    glip_out_valid = 1'b0;
    glip_out_data  = '0;
    glip_in_ready  = 1'b1;
    glip_q.delete();
    host_send(16'hE001, 1'b0);
    host_send(16'hE002, 1'b1);
    idle(5);
    exp_q = {16'h0002, 16'hE001, 16'hE002};
    check_glip("post_reset_tx");
    check_eq("reset_no_tx_drop", tx_drop_seen - base_tx, 32'd0);
    check_eq("reset_no_rx_drop", rx_drop_seen - base_rx, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mpsoc_glip_packetizer.md
# mpsoc_glip_packetizer

Host-side framing stage that sits directly on the GLIP channel pair of the `riscv_mpsoc4d` system. It sends DII debug packets into the system's `c_glip_in` and receives them from `c_glip_out`. On transmit it converts a host packet stream (words with a last marker) into the length-prefixed GLIP word stream the debug interface expects. On receive it strips the length word and re-delimits packets, dropping malformed ones.

## Interface
Parameters:
- `DATA_WIDTH`, 16, GLIP/DII word width.
- `MAX_PKT_LEN`, 12, maximum payload words per packet; must equal CONFIG `DEBUG_MAX_PKT_LEN`.
- `LEN_WIDTH`, `$clog2(MAX_PKT_LEN+1)`, counter width (derived).

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `host_in_data` in DATA_WIDTH: TX payload word.
- `host_in_last` in 1: marks the final word of a TX packet.
- `host_in_valid` in 1 / `host_in_ready` out 1: TX host handshake.
- `host_out_data` out DATA_WIDTH: RX payload word.
- `host_out_last` out 1: marks the final word of an RX packet.
- `host_out_valid` out 1 / `host_out_ready` in 1: RX host handshake.
- `glip_in_data` out DATA_WIDTH, `glip_in_valid` out 1, `glip_in_ready` in 1: drive system `c_glip_in`.
- `glip_out_data` in DATA_WIDTH, `glip_out_valid` in 1, `glip_out_ready` out 1: consume system `c_glip_out`.
- `tx_drop` out 1: one-cycle pulse when a TX packet is discarded.
- `rx_drop` out 1: one-cycle pulse when an RX packet is discarded.

## Operation
- **Transfer rule.** Every handshake transfers a word on a cycle where valid & ready. A valid, once raised, holds its data stable until accepted.
- **TX path.** Store-and-forward through a MAX_PKT_LEN-entry buffer. FSM states TX_COLLECT, TX_DROP, TX_LEN, TX_BODY.
  - TX_COLLECT: `host_in_ready`=1. Each accepted word is written at index `cnt`, then `cnt++`.
    - Accepted word with `last` and `cnt+1 <= MAX_PKT_LEN` → TX_LEN.
    - Accepted word with `cnt == MAX_PKT_LEN` (buffer full): the word is discarded. If it is `last`, pulse `tx_drop` and go to TX_COLLECT with `cnt`=0. Otherwise go to TX_DROP.
  - TX_DROP: `host_in_ready`=1. Words are discarded. On the accepted `last`, pulse `tx_drop`, set `cnt`=0, go to TX_COLLECT.
  - TX_LEN: `host_in_ready`=0, `glip_in_valid`=1, `glip_in_data`=zero-extended `cnt`. On accept → TX_BODY with `rd`=0.
  - TX_BODY: `glip_in_valid`=1, `glip_in_data`=`buf[rd]`. On accept `rd++`. On acceptance of the word at `rd == cnt-1`, go to TX_COLLECT with `cnt`=0.
- **RX path.** FSM states RX_LEN, RX_BODY, RX_DROP, with a down-counter `rem`.
  - RX_LEN: `glip_out_ready`=1, `host_out_valid`=0.
    - Accepted word 0 is an idle filler: ignore it and stay.
    - Accepted word greater than MAX_PKT_LEN: pulse `rx_drop`, set `rem`=word, go to RX_DROP.
    - Otherwise set `rem`=word and go to RX_BODY.
  - RX_BODY: combinational pass-through.
    - `host_out_valid`=`glip_out_valid`, `glip_out_ready`=`host_out_ready`, `host_out_data`=`glip_out_data`, `host_out_last`=(`rem`==1).
    - On each transfer `rem--`; transfer with `rem`==1 → RX_LEN.
  - RX_DROP: `glip_out_ready`=1. Each accepted word decrements `rem`; accepted word at `rem`==1 → RX_LEN. The `rem` counter is DATA_WIDTH wide, so lengths up to 65535 are drained correctly.
- **Independence.** TX and RX are fully independent, and simultaneous events on both paths are legal.

## Timing
- **Reset.** While `rst`=1, all outputs are 0: `host_in_ready`, `glip_out_ready`, both valids, data, last, and both drop pulses. On the first cycle after `rst` falls, the FSMs are in TX_COLLECT and RX_LEN with counters at 0.
- **Mid-packet reset.** Reset asserted mid-packet discards all partial state without pulsing `tx_drop` or `rx_drop`.
- **TX latency.** The length word becomes valid on the cycle after `last` is accepted. With `glip_in_ready` held high, an N-word packet occupies N+1 GLIP cycles back to back. `host_in_ready` is low from the cycle after `last` until the final body word is accepted.
- **RX latency.** Body words have zero latency, being combinational from `glip_out_*` to `host_out_*`. The length word costs one cycle.
- **Backpressure.** `glip_in_ready`=0 stalls TX_LEN and TX_BODY indefinitely with data held stable. `host_out_ready`=0 stalls the GLIP receive side in RX_BODY.
- **Drop pulses.** `tx_drop` and `rx_drop` are registered and high for exactly one cycle each, one cycle after the triggering transfer.

## Structure
- **Package `mpsoc_glip_packetizer_pkg`:** `tx_state_t` and `rx_state_t` enums, plus the `GLIP_WORD_WIDTH`=16 constant.
- **Sub-module `mpsoc_glip_tx_buffer`:** the single-write/single-read packet buffer (depth MAX_PKT_LEN, registered write, combinational read). TX FSM, RX FSM and counters stay in the top module.

## Test plan
- **Single TX packet.** Host sends 3 words 0x1111, 0x2222, 0x3333 (last on the third) with `glip_in_ready`=1 → GLIP sees 0x0003, 0x1111, 0x2222, 0x3333 on consecutive cycles, with `host_in_ready`=0 during these 4 cycles.
- **TX overflow.** Host sends a 14-word packet (MAX 12) → no GLIP traffic, and `tx_drop` pulses once after the 14th word. The next 1-word packet 0xABCD yields 0x0001, 0xABCD.
- **RX normal.** GLIP delivers 0x0000, 0x0002, 0xBEEF, 0xCAFE → host receives 0xBEEF then 0xCAFE, with last only on 0xCAFE; the filler word is invisible.
- **RX oversize.** GLIP delivers 0x0014 followed by 20 words, then 0x0001, 0x5A5A → `rx_drop` pulses once, the 20 words are consumed silently, and the host receives only 0x5A5A with last.
- **Backpressure and reset.** Toggle `glip_in_ready`/`host_out_ready` randomly mid-packet → data stays stable and no words are lost or duplicated. Assert `rst` mid TX_BODY → all outputs are 0 next cycle and a fresh packet transmits correctly afterwards.
